// File: rtl/l1_cache_4way.sv
// Blocking 4-way set-associative write-back / write-allocate L1 cache, 16 sets x 32 B lines,
// tree pseudo-LRU replacement, one outstanding CPU request.
module l1_cache_4way (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [31:0]  i_ufp_addr,
  input  logic [3:0]   i_ufp_rmask,
  input  logic [3:0]   i_ufp_wmask,
  input  logic [31:0]  i_ufp_wdata,
  output logic [31:0]  o_ufp_rdata,
  output logic         o_ufp_resp,
  output logic [31:0]  o_dfp_addr,
  output logic         o_dfp_read,
  output logic         o_dfp_write,
  input  logic [255:0] i_dfp_rdata,
  output logic [255:0] o_dfp_wdata,
  input  logic         i_dfp_resp
);

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StWriteback,
    StAllocate,
    StFill
  } state_e;

  state_e       r_state;
  logic [22:0]  r_tag   [4][16];
  logic [255:0] r_data  [4][16];
  logic [15:0]  r_valid [4];
  logic [15:0]  r_dirty [4];
  logic [2:0]   r_plru  [16];
  logic [1:0]   r_victim;

  logic         r_ufp_resp;
  logic [31:0]  r_ufp_rdata;
  logic [31:0]  r_dfp_addr;
  logic         r_dfp_read;
  logic         r_dfp_write;
  logic [255:0] r_dfp_wdata;

  logic [22:0]  w_tag;
  logic [3:0]   w_set;
  logic [2:0]   w_word;
  logic         w_rd;
  logic         w_wr;
  logic         w_hit;
  logic [1:0]   w_hit_way;
  logic [1:0]   w_victim;
  logic [2:0]   w_plru_cur;
  logic [2:0]   w_plru_next;
  logic [255:0] w_hit_line;
  logic [31:0]  w_hit_word;
  logic [255:0] w_merged_line;
  logic         w_victim_dirty;
  logic         w_unused_addr;

  assign w_tag  = i_ufp_addr[31:9];
  assign w_set  = i_ufp_addr[8:5];
  assign w_word = i_ufp_addr[4:2];
  assign w_rd   = |i_ufp_rmask;
  assign w_wr   = |i_ufp_wmask;
  assign w_unused_addr = ^i_ufp_addr[1:0];

  // Tag lookup; descending scan so the lowest matching way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = 2'd0;
    for (int w = 3; w >= 0; w--) begin
      if (r_valid[w][w_set] && (r_tag[w][w_set] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = 2'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise follow the PLRU tree.
  always_comb begin
    w_plru_cur = r_plru[w_set];
    if (w_plru_cur[0]) begin
      w_victim = w_plru_cur[2] ? 2'd3 : 2'd2;
    end else begin
      w_victim = w_plru_cur[1] ? 2'd1 : 2'd0;
    end
    for (int w = 3; w >= 0; w--) begin
      if (!r_valid[w][w_set]) begin
        w_victim = 2'(w);
      end
    end
  end

  assign w_victim_dirty = r_valid[w_victim][w_set] && r_dirty[w_victim][w_set];

  // Point the tree away from the way just accessed.
  always_comb begin
    w_plru_next = w_plru_cur;
    unique case (w_hit_way)
      2'd0: begin w_plru_next[0] = 1'b1; w_plru_next[1] = 1'b1; end
      2'd1: begin w_plru_next[0] = 1'b1; w_plru_next[1] = 1'b0; end
      2'd2: begin w_plru_next[0] = 1'b0; w_plru_next[2] = 1'b1; end
      2'd3: begin w_plru_next[0] = 1'b0; w_plru_next[2] = 1'b0; end
    endcase
  end

  always_comb begin
    w_hit_line    = r_data[w_hit_way][w_set];
    w_hit_word    = w_hit_line[{w_word, 5'd0} +: 32];
    w_merged_line = w_hit_line;
    for (int b = 0; b < 4; b++) begin
      if (i_ufp_wmask[b]) begin
        w_merged_line[{w_word, 5'd0} + 8'(b * 8) +: 8] = i_ufp_wdata[b * 8 +: 8];
      end
    end
  end

  // Tag and data arrays carry no reset; validity is tracked separately.
  always_ff @(posedge i_clk) begin
    if (i_rst && (r_state == StAllocate) && i_dfp_resp) begin
      r_tag[r_victim][w_set]  <= w_tag;
      r_data[r_victim][w_set] <= i_dfp_rdata;
    end else if (i_rst && (r_state == StCompare) && w_hit && w_wr) begin
      r_data[w_hit_way][w_set] <= w_merged_line;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= StIdle;
      r_victim    <= 2'd0;
      r_ufp_resp  <= 1'b0;
      r_ufp_rdata <= '0;
      r_dfp_addr  <= '0;
      r_dfp_read  <= 1'b0;
      r_dfp_write <= 1'b0;
      r_dfp_wdata <= '0;
      for (int w = 0; w < 4; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
      for (int s = 0; s < 16; s++) begin
        r_plru[s] <= '0;
      end
    end else begin
      r_ufp_resp <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_rd || w_wr) begin
            r_state <= StCompare;
          end
        end
        StCompare: begin
          if (w_hit) begin
            r_ufp_resp    <= 1'b1;
            r_plru[w_set] <= w_plru_next;
            if (w_rd) begin
              r_ufp_rdata <= w_hit_word;
            end
            if (w_wr) begin
              r_dirty[w_hit_way][w_set] <= 1'b1;
            end
            r_state <= StIdle;
          end else if (w_victim_dirty) begin
            r_victim    <= w_victim;
            r_dfp_write <= 1'b1;
            r_dfp_addr  <= {r_tag[w_victim][w_set], w_set, 5'd0};
            r_dfp_wdata <= r_data[w_victim][w_set];
            r_state     <= StWriteback;
          end else begin
            r_victim   <= w_victim;
            r_dfp_read <= 1'b1;
            r_dfp_addr <= {i_ufp_addr[31:5], 5'd0};
            r_state    <= StAllocate;
          end
        end
        StWriteback: begin
          if (i_dfp_resp) begin
            r_dfp_write <= 1'b0;
            r_dfp_read  <= 1'b1;
            r_dfp_addr  <= {i_ufp_addr[31:5], 5'd0};
            r_state     <= StAllocate;
          end
        end
        StAllocate: begin
          if (i_dfp_resp) begin
            r_dfp_read                <= 1'b0;
            r_valid[r_victim][w_set] <= 1'b1;
            r_dirty[r_victim][w_set] <= 1'b0;
            r_state                   <= StFill;
          end
        end
        StFill: begin
          r_state <= StCompare;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_ufp_resp  = r_ufp_resp;
  assign o_ufp_rdata = r_ufp_rdata;
  assign o_dfp_addr  = r_dfp_addr;
  assign o_dfp_read  = r_dfp_read;
  assign o_dfp_write = r_dfp_write;
  assign o_dfp_wdata = r_dfp_wdata;

endmodule

// File: tb/tb_l1_cache_4way.sv
// Directed bench for l1_cache_4way: behavioural line memory plus hand-computed expectations.
module tb_l1_cache_4way;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  i_ufp_addr;
  logic [3:0]   i_ufp_rmask;
  logic [3:0]   i_ufp_wmask;
  logic [31:0]  i_ufp_wdata;
  logic [31:0]  o_ufp_rdata;
  logic         o_ufp_resp;
  logic [31:0]  o_dfp_addr;
  logic         o_dfp_read;
  logic         o_dfp_write;
  logic [255:0] i_dfp_rdata;
  logic [255:0] o_dfp_wdata;
  logic         i_dfp_resp;

  int n_checks = 0;
  int n_fail   = 0;
  int n_both   = 0;
  bit mem_en   = 1'b1;

  logic [255:0] mem [logic [31:0]];
  logic [31:0]  rd_addr;
  logic [31:0]  wb_addr;
  logic [255:0] wb_line;
  logic [31:0]  rd;
  int           lat, rc, wc;

  always #5 clk = ~clk;

  l1_cache_4way u_dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_ufp_addr  (i_ufp_addr),
    .i_ufp_rmask (i_ufp_rmask),
    .i_ufp_wmask (i_ufp_wmask),
    .i_ufp_wdata (i_ufp_wdata),
    .o_ufp_rdata (o_ufp_rdata),
    .o_ufp_resp  (o_ufp_resp),
    .o_dfp_addr  (o_dfp_addr),
    .o_dfp_read  (o_dfp_read),
    .o_dfp_write (o_dfp_write),
    .i_dfp_rdata (i_dfp_rdata),
    .o_dfp_wdata (o_dfp_wdata),
    .i_dfp_resp  (i_dfp_resp)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mem_rd(input logic [31:0] la);
    return mem.exists(la) ? mem[la] : '0;
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] d);
    logic [31:0]  la;
    logic [255:0] l;
    la = {a[31:5], 5'd0};
    l  = mem_rd(la);
    l[{a[4:2], 5'd0} +: 32] = d;
    mem[la] = l;
  endtask

  always @(negedge clk) begin
    if (o_dfp_read && o_dfp_write) n_both++;
  end

  // Line memory: answers two cycles after it sees a request, one-cycle resp pulse.
  initial begin
    i_dfp_resp  = 1'b0;
    i_dfp_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_en && (o_dfp_read || o_dfp_write)) begin
        repeat (2) @(negedge clk);
        if (mem_en && rst_n) begin
          if (o_dfp_write) mem[o_dfp_addr] = o_dfp_wdata;
          else i_dfp_rdata = mem_rd(o_dfp_addr);
          i_dfp_resp = 1'b1;
          @(negedge clk);
          i_dfp_resp = 1'b0;
        end
      end
    end
  end

  task automatic req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                     input logic [31:0] wd, output logic [31:0] rdo, output int lo,
                     output int rco, output int wco);
    i_ufp_addr  = a;
    i_ufp_rmask = rm;
    i_ufp_wmask = wm;
    i_ufp_wdata = wd;
    lo = 0; rco = 0; wco = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (o_dfp_read && rco == 0) begin rco = c; rd_addr = o_dfp_addr; end
      if (o_dfp_write && wco == 0) begin wco = c; wb_addr = o_dfp_addr; wb_line = o_dfp_wdata; end
      if (o_ufp_resp) begin lo = c; break; end
    end
    rdo = o_ufp_rdata;
    i_ufp_rmask = 4'h0;
    i_ufp_wmask = 4'h0;
  endtask

  task automatic rd_hit(input string tag, input logic [31:0] a, input logic [31:0] exp);
    req(a, 4'hF, 4'h0, 32'h0, rd, lat, rc, wc);
    check({tag, "_data"}, rd, exp);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_dfp"}, rc + wc, 0);
  endtask

  task automatic rd_miss(input string tag, input logic [31:0] a, input logic [31:0] exp);
    req(a, 4'hF, 4'h0, 32'h0, rd, lat, rc, wc);
    check({tag, "_data"}, rd, exp);
    check({tag, "_lat"}, lat, 7);
    check({tag, "_rdcyc"}, rc, 2);
    check({tag, "_wrcyc"}, wc, 0);
    check({tag, "_addr"}, rd_addr, {a[31:5], 5'd0});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    put(32'h000, 32'h88888888); put(32'h008, 32'h66666666); put(32'h00C, 32'h55555555);
    put(32'h010, 32'h44444444); put(32'h01C, 32'h11111111); put(32'h20C, 32'hCCCCCCCC);
    put(32'h218, 32'h99999999); put(32'h200, 32'hFFFFFFFF); put(32'h02C, 32'h12345678);
    put(32'h600, 32'h403202B3); put(32'h60C, 32'h403202B3); put(32'h400, 32'h9876ABCD);
    put(32'h404, 32'h9876ABCD); put(32'h40C, 32'h9876ABCD); put(32'h80C, 32'h003262B3);

    rst_n = 1'b0; i_ufp_addr = '0; i_ufp_rmask = '0; i_ufp_wmask = '0; i_ufp_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_resp", o_ufp_resp, 0);
    check("rst_rdata", o_ufp_rdata, 0);
    check("rst_dfp_rw", {o_dfp_read, o_dfp_write}, 0);
    check("rst_dfp_addr", o_dfp_addr, 0);
    check("rst_dfp_wdata", o_dfp_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    rd_miss("t1_cold_000", 32'h000, 32'h88888888);
    rd_hit("t2_000", 32'h000, 32'h88888888);
    rd_hit("t2_008", 32'h008, 32'h66666666);
    rd_hit("t2_01c", 32'h01C, 32'h11111111);

    rd_miss("t3_20c", 32'h20C, 32'hCCCCCCCC);
    rd_hit("t3_218", 32'h218, 32'h99999999);
    rd_hit("t3_00c", 32'h00C, 32'h55555555);

    rd_miss("t4_02c", 32'h02C, 32'h12345678);
    rd_hit("t4_200", 32'h200, 32'hFFFFFFFF);
    rd_hit("t4_008", 32'h008, 32'h66666666);

    rd_miss("t5_60c", 32'h60C, 32'h403202B3);
    rd_miss("t5_40c", 32'h40C, 32'h9876ABCD);
    rd_miss("t5_80c", 32'h80C, 32'h003262B3);
    rd_hit("t5_000", 32'h000, 32'h88888888);
    rd_hit("t5_600", 32'h600, 32'h403202B3);
    rd_hit("t5_404", 32'h404, 32'h9876ABCD);
    rd_miss("t5_20c_again", 32'h20C, 32'hCCCCCCCC);
    rd_hit("t5_600b", 32'h600, 32'h403202B3);
    rd_hit("t5_404b", 32'h404, 32'h9876ABCD);
    rd_miss("t5_80c_again", 32'h80C, 32'h003262B3);

    // Write miss into the 0x600 way; read data must keep the last read value.
    req(32'h004, 4'h0, 4'hF, 32'hA5A5A5A5, rd, lat, rc, wc);
    check("t6_wr_rdata_held", rd, 32'h003262B3);
    check("t6_wr_lat", lat, 7);
    check("t6_wr_rdcyc", rc, 2);
    check("t6_wr_wrcyc", wc, 0);
    rd_miss("t6_a00", 32'hA00, 32'h0);
    rd_miss("t6_c00", 32'hC00, 32'h0);
    rd_miss("t6_e00", 32'hE00, 32'h0);
    req(32'h1000, 4'hF, 4'h0, 32'h0, rd, lat, rc, wc);
    check("t6_wb_wrcyc", wc, 2);
    check("t6_wb_rdcyc", rc, 5);
    check("t6_wb_lat", lat, 11);
    check("t6_wb_addr", wb_addr, 32'h000);
    check("t6_wb_word1", wb_line[63:32], 32'hA5A5A5A5);
    check("t6_wb_word0", wb_line[31:0], 32'h88888888);
    check("t6_rd_addr", rd_addr, 32'h1000);
    check("t6_1000_data", rd, 32'h0);
    rd_miss("t6_readback", 32'h004, 32'hA5A5A5A5);

    // Reset while the cache waits in ALLOCATE.
    mem_en = 1'b0;
    i_ufp_addr = 32'h1E00; i_ufp_rmask = 4'hF;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_dfp_read) begin seen = 1'b1; break; end
    end
    check("t6_alloc_reached", seen, 1);
    rst_n = 1'b0; i_ufp_rmask = 4'h0;
    @(negedge clk);
    check("t6_rst_dfp_read", o_dfp_read, 0);
    check("t6_rst_resp", o_ufp_resp, 0);
    check("t6_rst_dfp_addr", o_dfp_addr, 0);
    rst_n = 1'b1; mem_en = 1'b1;
    @(negedge clk);
    rd_miss("t6_post_rst_1000", 32'h1000, 32'h0);
    rd_miss("t6_post_rst_004", 32'h004, 32'hA5A5A5A5);

    check("rw_exclusive", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
